// File: rtl/datapath_sequencer_if.sv
// Instruction handshake plus datapath control bundle between the sequencer and its neighbours.
// master: instruction source / datapath side; slave: the sequencer.
interface datapath_sequencer_if #(
  parameter int unsigned COUNT_W = 16
);
  logic               instr_valid;
  logic               instr_ready;
  logic [31:0]        instr;
  logic               zero_flag;
  logic [4:0]         read_reg_num1;
  logic [4:0]         read_reg_num2;
  logic [4:0]         write_reg;
  logic [3:0]         alu_control;
  logic               regwrite;
  logic               last_zero;
  logic               illegal_instr;
  logic [COUNT_W-1:0] retired_count;

  modport master (
    output instr_valid, instr, zero_flag,
    input  instr_ready, read_reg_num1, read_reg_num2, write_reg, alu_control,
    input  regwrite, last_zero, illegal_instr, retired_count
  );

  modport slave (
    input  instr_valid, instr, zero_flag,
    output instr_ready, read_reg_num1, read_reg_num2, write_reg, alu_control,
    output regwrite, last_zero, illegal_instr, retired_count
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Sequences RV32I R-type instructions through DECODE/EXEC for the register-file/ALU datapath.
// Define DATAPATH_SEQ_RETIRE_COUNT_EN to build the retired-instruction counter.
module datapath_sequencer #(
  parameter int unsigned COUNT_W      = 16,
  parameter logic [6:0]  OPCODE_RTYPE = 7'b0110011
) (
  input logic                 clock,
  input logic                 reset,
  datapath_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StErr} state_e;

  state_e     state_q, state_d;
  logic [4:0] rs1_q, rs2_q, rd_q;
  logic [3:0] alu_q;
  logic       last_zero_q;
  logic [3:0] alu_dec;
  logic       funct_ok;
  logic       legal;
  logic       accept;

  always_comb begin
    alu_dec  = 4'b0000;
    funct_ok = 1'b1;
    case ({bus.instr[31:25], bus.instr[14:12]})
      10'b0000000_000: alu_dec = 4'b0010;
      10'b0100000_000: alu_dec = 4'b0110;
      10'b0000000_111: alu_dec = 4'b0000;
      10'b0000000_110: alu_dec = 4'b0001;
      10'b0000000_100: alu_dec = 4'b0011;
      10'b0000000_001: alu_dec = 4'b0100;
      10'b0000000_101: alu_dec = 4'b0101;
      10'b0100000_101: alu_dec = 4'b1001;
      10'b0000000_010: alu_dec = 4'b0111;
      10'b0000000_011: alu_dec = 4'b1000;
      default:         funct_ok = 1'b0;
    endcase
  end

  assign legal  = funct_ok && (bus.instr[6:0] == OPCODE_RTYPE);
  assign accept = bus.instr_valid && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = legal ? StDecode : StErr;
      StDecode: state_d = StExec;
      StExec:   state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Field registers only load on a legal accept so ERR and IDLE keep the previous values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      alu_q <= '0;
    end else if (accept && legal) begin
      rs1_q <= bus.instr[19:15];
      rs2_q <= bus.instr[24:20];
      rd_q  <= bus.instr[11:7];
      alu_q <= alu_dec;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_zero_q <= 1'b0;
    end else if (state_q == StExec) begin
      last_zero_q <= bus.zero_flag;
    end
  end

`ifdef DATAPATH_SEQ_RETIRE_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (state_q == StExec) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign bus.retired_count = count_q;
`else
  assign bus.retired_count = '0;
`endif

  assign bus.instr_ready   = (state_q == StIdle);
  assign bus.illegal_instr = (state_q == StErr);
  // Writes to x0 are suppressed but the instruction still retires.
  assign bus.regwrite      = (state_q == StExec) && (rd_q != 5'd0);
  assign bus.read_reg_num1 = rs1_q;
  assign bus.read_reg_num2 = rs2_q;
  assign bus.write_reg     = rd_q;
  assign bus.alu_control   = alu_q;
  assign bus.last_zero     = last_zero_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer; counter built with COUNT_W=2 to exercise wrap.
module tb_datapath_sequencer;

  localparam int unsigned CountW = 2;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  datapath_sequencer_if #(.COUNT_W(CountW)) bus ();

  datapath_sequencer #(.COUNT_W(CountW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef DATAPATH_SEQ_RETIRE_COUNT_EN
    return 32'(n % (1 << CountW));
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    bus.zero_flag   = 1'b0;
    #20;
    reset = 1'b0;
    #1;
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_rs1", bus.read_reg_num1, 0);
    chk("rst_rs2", bus.read_reg_num2, 0);
    chk("rst_rd", bus.write_reg, 0);
    chk("rst_alu", bus.alu_control, 0);
    chk("rst_regwrite", bus.regwrite, 0);
    chk("rst_last_zero", bus.last_zero, 0);
    chk("rst_illegal", bus.illegal_instr, 0);
    chk("rst_count", bus.retired_count, 0);

    // add x3,x1,x2
    bus.instr       = 32'h002081B3;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    chk("add_dec_ready", bus.instr_ready, 0);
    chk("add_dec_rs1", bus.read_reg_num1, 1);
    chk("add_dec_rs2", bus.read_reg_num2, 2);
    chk("add_dec_rd", bus.write_reg, 3);
    chk("add_dec_alu", bus.alu_control, 4'b0010);
    chk("add_dec_regwrite", bus.regwrite, 0);
    step();
    chk("add_exec_regwrite", bus.regwrite, 1);
    chk("add_exec_ready", bus.instr_ready, 0);
    step();
    chk("add_idle_ready", bus.instr_ready, 1);
    chk("add_idle_regwrite", bus.regwrite, 0);
    chk("add_count", bus.retired_count, exp_cnt(1));
    chk("add_hold_rd", bus.write_reg, 3);

    // sub x5,x1,x2 with zero_flag high during EXEC
    bus.instr       = 32'h402082B3;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    chk("sub_dec_alu", bus.alu_control, 4'b0110);
    chk("sub_dec_rd", bus.write_reg, 5);
    bus.zero_flag = 1'b1;
    step();
    chk("sub_exec_regwrite", bus.regwrite, 1);
    step();
    bus.zero_flag = 1'b0;
    chk("sub_last_zero", bus.last_zero, 1);
    chk("sub_count", bus.retired_count, exp_cnt(2));

    // add x0,x1,x2: retires without a write
    bus.instr       = 32'h00208033;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    chk("x0_dec_regwrite", bus.regwrite, 0);
    chk("x0_dec_rd", bus.write_reg, 0);
    step();
    chk("x0_exec_regwrite", bus.regwrite, 0);
    step();
    chk("x0_count", bus.retired_count, exp_cnt(3));
    chk("x0_last_zero", bus.last_zero, 0);

    // Opcode mismatch
    bus.instr       = 32'h00000013;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    chk("ill_pulse", bus.illegal_instr, 1);
    chk("ill_regwrite", bus.regwrite, 0);
    chk("ill_ready", bus.instr_ready, 0);
    chk("ill_hold_alu", bus.alu_control, 4'b0010);
    step();
    chk("ill_pulse_end", bus.illegal_instr, 0);
    chk("ill_regwrite_idle", bus.regwrite, 0);
    chk("ill_ready_back", bus.instr_ready, 1);
    chk("ill_count", bus.retired_count, exp_cnt(3));

    // R-type opcode but unlisted funct7 (MUL encoding)
    bus.instr       = 32'h022081B3;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    chk("mul_illegal", bus.illegal_instr, 1);
    step();

    // sra x5,x1,x2
    bus.instr       = 32'h4020D2B3;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    chk("sra_dec_alu", bus.alu_control, 4'b1001);
    chk("sra_illegal", bus.illegal_instr, 0);
    step();
    step();
    chk("sra_count", bus.retired_count, exp_cnt(4));

    // Reset asserted during DECODE aborts the sequence
    bus.instr       = 32'h002081B3;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    chk("rstmid_dec_rd", bus.write_reg, 3);
    reset = 1'b1;
    #1;
    chk("rstmid_rd_cleared", bus.write_reg, 0);
    chk("rstmid_regwrite", bus.regwrite, 0);
    #2;
    reset = 1'b0;
    step();
    chk("rstmid_ready", bus.instr_ready, 1);
    chk("rstmid_no_regwrite", bus.regwrite, 0);
    chk("rstmid_count", bus.retired_count, 0);
    chk("rstmid_last_zero", bus.last_zero, 0);

    // Back-to-back: and x4,x1,x2 then add x3,x1,x2 with valid held high
    bus.instr       = 32'h0020F233;
    bus.instr_valid = 1'b1;
    step();
    chk("b2b_first_alu", bus.alu_control, 4'b0000);
    chk("b2b_first_rd", bus.write_reg, 4);
    bus.instr = 32'h002081B3;
    step();
    chk("b2b_exec_ready", bus.instr_ready, 0);
    step();
    chk("b2b_idle_ready", bus.instr_ready, 1);
    chk("b2b_first_count", bus.retired_count, exp_cnt(1));
    step();
    chk("b2b_second_alu", bus.alu_control, 4'b0010);
    chk("b2b_second_rd", bus.write_reg, 3);
    chk("b2b_second_ready", bus.instr_ready, 0);
    step();
    step();
    chk("b2b_second_count", bus.retired_count, exp_cnt(2));

    // Three more retires: five since reset wraps a 2-bit counter to 1
    for (int i = 0; i < 9; i++) step();
    bus.instr_valid = 1'b0;
    chk("wrap_ready", bus.instr_ready, 1);
    chk("wrap_count", bus.retired_count, exp_cnt(5));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
